// File: rtl/bus_master_port.sv
// bus_master_port: master-side serial bus engine. Serialises one parallel
// request (slave ID, address, optional write data) onto the single-wire bus,
// handshakes with the slave over the wired busy line and returns read data or
// a completion/timeout pulse to the local master.
module bus_master_port #(
  parameter int unsigned ADDRESS_WIDTH = 15,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned RX_LATENCY    = 2,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req,
  input  logic                     req_rd_wrt,
  input  logic [1:0]               req_slave_id,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     bus_util,
  output logic                     rd_wrt,
  inout  wire                      data_bus_serial,
  inout  wire                      slave_busy
);

  localparam int unsigned TXW = 2 + ADDRESS_WIDTH + DATA_WIDTH;
  localparam int unsigned CW  = 16;
  localparam int unsigned TW  = 8;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_SID, S_ADDR, S_WDATA,
    S_WAIT_WR, S_WAIT_RD, S_ACK, S_RX, S_DONE, S_ERR
  } state_e;

  state_e                  state_q, state_d;
  logic [TXW-1:0]          tx_q, tx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0]   rx_q, rx_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rd_wrt_q, rd_wrt_d;
  logic                    dbs_oe, dbs_out, sb_oe;
  logic [TW-1:0]           tmo_inc;
  logic [CW-1:0]           last_cnt;

  assign tmo_inc  = tmo_q + TW'(1);
  assign last_cnt = (state_q == S_SID)  ? CW'(1) :
                    (state_q == S_ADDR) ? CW'(ADDRESS_WIDTH - 1) :
                                          CW'(DATA_WIDTH - 1);

  // Lines are released (Z) unless this block owns them in the current state.
  assign data_bus_serial = dbs_oe ? dbs_out : 1'bz;
  assign slave_busy      = sb_oe  ? 1'b1    : 1'bz;

  assign busy     = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign bus_util = busy;
  assign done     = (state_q == S_DONE);
  assign error    = (state_q == S_ERR);
  assign rdata    = rdata_q;
  assign rd_wrt   = rd_wrt_q;

  // State and datapath registers; reset releases both lines immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      tx_q     <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      rx_q     <= '0;
      rdata_q  <= '0;
      rd_wrt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      rd_wrt_q <= rd_wrt_d;
    end
  end

  // Next-state, shift/sample datapath and line enables.
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    rd_wrt_d = rd_wrt_q;
    dbs_oe   = 1'b0;
    dbs_out  = 1'b0;
    sb_oe    = 1'b0;
    case (state_q)
      // DONE accepts a held req so back-to-back requests start the very next cycle.
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (req) begin
          state_d  = S_START;
          tx_d     = {req_slave_id, req_addr, req_wdata};
          rd_wrt_d = req_rd_wrt;
          cnt_d    = '0;
        end
      end
      S_START: begin
        dbs_oe  = 1'b1;
        dbs_out = 1'b0;
        state_d = S_SID;
      end
      // ID, address and write data share one MSB-first shift register.
      S_SID, S_ADDR, S_WDATA: begin
        dbs_oe  = 1'b1;
        dbs_out = tx_q[TXW-1];
        tx_d    = {tx_q[TXW-2:0], 1'b0};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == last_cnt) begin
          cnt_d = '0;
          tmo_d = '0;
          case (state_q)
            S_SID:   state_d = S_ADDR;
            S_ADDR:  state_d = rd_wrt_q ? S_WDATA : S_WAIT_RD;
            default: state_d = S_WAIT_WR;
          endcase
        end
      end
      // Completion is checked before the timeout so it wins on the final cycle.
      S_WAIT_WR, S_WAIT_RD: begin
        if (slave_busy == 1'b0) begin
          state_d = (state_q == S_WAIT_WR) ? S_DONE : S_ACK;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TW'(TIMEOUT)) begin
            state_d = S_ERR;
          end
        end
      end
      S_ACK: begin
        sb_oe   = 1'b1;
        cnt_d   = '0;
        state_d = S_RX;
      end
      S_RX: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q >= CW'(RX_LATENCY - 1)) begin
          rx_d = DATA_WIDTH'({rx_q, data_bus_serial});
        end
        if (cnt_q == CW'(RX_LATENCY + DATA_WIDTH - 2)) begin
          state_d = S_DONE;
          rdata_d = rx_d;
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_master_port.sv
// tb_bus_master_port: directed scenarios with hand-computed bus sequences.
module tb_bus_master_port;

  logic        clk, rstn, req, req_rd_wrt;
  logic [1:0]  req_slave_id;
  logic [14:0] req_addr;
  logic [7:0]  req_wdata;
  logic        busy, done, error, bus_util, rd_wrt;
  logic [7:0]  rdata;
  wire         data_bus_serial, slave_busy;
  logic        tb_dbs_en, tb_dbs_v, tb_sb_en, tb_sb_v;
  int          n_cmp, n_bad;

  assign data_bus_serial = tb_dbs_en ? tb_dbs_v : 1'bz;
  assign slave_busy      = tb_sb_en  ? tb_sb_v  : 1'bz;

  bus_master_port #(
    .ADDRESS_WIDTH(15),
    .DATA_WIDTH   (8),
    .RX_LATENCY   (2),
    .TIMEOUT      (255)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .req            (req),
    .req_rd_wrt     (req_rd_wrt),
    .req_slave_id   (req_slave_id),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .rdata          (rdata),
    .bus_util       (bus_util),
    .rd_wrt         (rd_wrt),
    .data_bus_serial(data_bus_serial),
    .slave_busy     (slave_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, bus_util, done, error, rd_wrt} !== 5'b00000) begin
      n_bad++; $display("FAIL rst_status: got %b want %b", {busy, bus_util, done, error, rd_wrt}, 5'b00000);
    end
    n_cmp++;
    if (rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rdata: got %h want %h", rdata, 8'h00); end
    n_cmp++;
    if (data_bus_serial === 1'b1) begin n_bad++; $display("FAIL rst_dbs_released: got %b want not 1", data_bus_serial); end
    n_cmp++;
    if (slave_busy === 1'b1) begin n_bad++; $display("FAIL rst_sb_released: got %b want not 1", slave_busy); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // Write id=10 addr=1234 wdata=A5; slave_busy falls on the 6th WAIT_WR cycle.
  task automatic test_write();
    logic [25:0] vec;
    vec = {1'b0, 2'b10, 15'h1234, 8'hA5};
    tb_sb_en = 1'b1; tb_sb_v = 1'b1; tb_dbs_en = 1'b0;
    req = 1'b1; req_rd_wrt = 1'b1; req_slave_id = 2'b10; req_addr = 15'h1234; req_wdata = 8'hA5;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 26; i++) begin
      n_cmp++;
      if (data_bus_serial !== vec[25-i]) begin
        n_bad++; $display("FAIL wr_bit%0d: got %b want %b", i, data_bus_serial, vec[25-i]);
      end
      n_cmp++;
      if ({busy, bus_util, done, error} !== 4'b1100) begin
        n_bad++; $display("FAIL wr_status%0d: got %b want %b", i, {busy, bus_util, done, error}, 4'b1100);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (data_bus_serial === 1'b1) begin n_bad++; $display("FAIL wr_wait_release%0d: got %b want not 1", k, data_bus_serial); end
      n_cmp++;
      if ({busy, bus_util, done, error} !== 4'b1100) begin
        n_bad++; $display("FAIL wr_wait_status%0d: got %b want %b", k, {busy, bus_util, done, error}, 4'b1100);
      end
      if (k == 5) tb_sb_v = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if ({busy, bus_util, done, error, rd_wrt} !== 5'b00101) begin
      n_bad++; $display("FAIL wr_done: got %b want %b", {busy, bus_util, done, error, rd_wrt}, 5'b00101);
    end
    n_cmp++;
    if (rdata !== 8'h00) begin n_bad++; $display("FAIL wr_rdata_kept: got %h want %h", rdata, 8'h00); end
    tb_sb_v = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, error} !== 3'b000) begin n_bad++; $display("FAIL wr_after: got %b want %b", {busy, done, error}, 3'b000); end
  endtask

  // Read id=01 addr=0007; slave ready on 3rd WAIT_RD cycle, returns 3C.
  task automatic test_read();
    logic [17:0] vec;
    logic [7:0]  d;
    vec = {1'b0, 2'b01, 15'h0007};
    d = 8'h3C;
    tb_sb_en = 1'b1; tb_sb_v = 1'b1; tb_dbs_en = 1'b0;
    req = 1'b1; req_rd_wrt = 1'b0; req_slave_id = 2'b01; req_addr = 15'h0007; req_wdata = 8'hFF;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 18; i++) begin
      n_cmp++;
      if (data_bus_serial !== vec[17-i]) begin
        n_bad++; $display("FAIL rd_bit%0d: got %b want %b", i, data_bus_serial, vec[17-i]);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (data_bus_serial === 1'b1) begin n_bad++; $display("FAIL rd_wait_release%0d: got %b want not 1", k, data_bus_serial); end
      n_cmp++;
      if ({busy, bus_util, done, error} !== 4'b1100) begin
        n_bad++; $display("FAIL rd_wait_status%0d: got %b want %b", k, {busy, bus_util, done, error}, 4'b1100);
      end
      if (k < 2) @(negedge clk);
    end
    tb_sb_v = 1'b0;
    @(posedge clk); #1; tb_sb_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (slave_busy !== 1'b1) begin n_bad++; $display("FAIL rd_ack_drive: got %b want %b", slave_busy, 1'b1); end
    @(negedge clk);
    n_cmp++;
    if (slave_busy === 1'b1) begin n_bad++; $display("FAIL rd_ack_one_cycle: got %b want not 1", slave_busy); end
    tb_sb_en = 1'b1; tb_sb_v = 1'b1;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL rd_rx_status%0d: got %b want %b", b, {busy, done}, 2'b10); end
      tb_dbs_en = 1'b1; tb_dbs_v = d[7-b];
    end
    @(negedge clk);
    tb_dbs_en = 1'b0;
    n_cmp++;
    if ({busy, bus_util, done, error, rd_wrt} !== 5'b00100) begin
      n_bad++; $display("FAIL rd_done: got %b want %b", {busy, bus_util, done, error, rd_wrt}, 5'b00100);
    end
    n_cmp++;
    if (rdata !== 8'h3C) begin n_bad++; $display("FAIL rd_rdata: got %h want %h", rdata, 8'h3C); end
    @(negedge clk);
    n_cmp++;
    if ({busy, done, rdata} !== {2'b00, 8'h3C}) begin
      n_bad++; $display("FAIL rd_after: got %b/%h want 00/3c", {busy, done}, rdata);
    end
  endtask

  // Read with slave_busy stuck at 1: error on WAIT_RD entry + 255 cycles.
  task automatic test_timeout();
    tb_sb_en = 1'b1; tb_sb_v = 1'b1; tb_dbs_en = 1'b0;
    req = 1'b1; req_rd_wrt = 1'b0; req_slave_id = 2'b11; req_addr = 15'h2AAB; req_wdata = 8'h00;
    @(negedge clk);
    req = 1'b0;
    repeat (18) @(negedge clk);
    for (int k = 0; k < 255; k++) begin
      n_cmp++;
      if ({busy, error} !== 2'b10) begin n_bad++; $display("FAIL to_wait%0d: got %b want %b", k, {busy, error}, 2'b10); end
      @(negedge clk);
    end
    n_cmp++;
    if ({busy, bus_util, done, error} !== 4'b0001) begin
      n_bad++; $display("FAIL to_error: got %b want %b", {busy, bus_util, done, error}, 4'b0001);
    end
    n_cmp++;
    if (rdata !== 8'h3C) begin n_bad++; $display("FAIL to_rdata_kept: got %h want %h", rdata, 8'h3C); end
    n_cmp++;
    if (data_bus_serial === 1'b1) begin n_bad++; $display("FAIL to_dbs_released: got %b want not 1", data_bus_serial); end
    @(negedge clk);
    n_cmp++;
    if ({busy, done, error} !== 3'b000) begin n_bad++; $display("FAIL to_after: got %b want %b", {busy, done, error}, 3'b000); end
  endtask

  // Reset asserted while address bit 7 is on the line, then a clean write.
  task automatic test_reset_mid();
    tb_sb_en = 1'b1; tb_sb_v = 1'b1; tb_dbs_en = 1'b0;
    req = 1'b1; req_rd_wrt = 1'b1; req_slave_id = 2'b11; req_addr = 15'h7FFF; req_wdata = 8'h00;
    @(negedge clk);
    req = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (data_bus_serial !== 1'b1) begin n_bad++; $display("FAIL rm_addr_bit7: got %b want %b", data_bus_serial, 1'b1); end
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({busy, bus_util, done, error, rd_wrt} !== 5'b00000) begin
      n_bad++; $display("FAIL rm_status: got %b want %b", {busy, bus_util, done, error, rd_wrt}, 5'b00000);
    end
    n_cmp++;
    if (rdata !== 8'h00) begin n_bad++; $display("FAIL rm_rdata: got %h want %h", rdata, 8'h00); end
    n_cmp++;
    if (data_bus_serial === 1'b1) begin n_bad++; $display("FAIL rm_dbs_released: got %b want not 1", data_bus_serial); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    test_write();
  endtask

  // req pulse mid-write is ignored; slave ready on the last allowed wait cycle.
  task automatic test_req_ignored();
    logic [25:0] vec;
    vec = {1'b0, 2'b00, 15'h4321, 8'h5A};
    tb_sb_en = 1'b1; tb_sb_v = 1'b1; tb_dbs_en = 1'b0;
    req = 1'b1; req_rd_wrt = 1'b1; req_slave_id = 2'b00; req_addr = 15'h4321; req_wdata = 8'h5A;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 26; i++) begin
      n_cmp++;
      if (data_bus_serial !== vec[25-i]) begin
        n_bad++; $display("FAIL ig_bit%0d: got %b want %b", i, data_bus_serial, vec[25-i]);
      end
      req = (i == 10);
      if (i == 10) begin
        req_rd_wrt = 1'b0; req_slave_id = 2'b11; req_addr = 15'h0000; req_wdata = 8'h00;
      end
      @(negedge clk);
    end
    for (int k = 0; k < 255; k++) begin
      n_cmp++;
      if ({busy, done, error} !== 3'b100) begin n_bad++; $display("FAIL ig_wait%0d: got %b want %b", k, {busy, done, error}, 3'b100); end
      if (k == 254) tb_sb_v = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if ({busy, bus_util, done, error, rd_wrt} !== 5'b00101) begin
      n_bad++; $display("FAIL ig_done_not_error: got %b want %b", {busy, bus_util, done, error, rd_wrt}, 5'b00101);
    end
    tb_sb_v = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, error} !== 3'b000) begin n_bad++; $display("FAIL ig_not_queued: got %b want %b", {busy, done, error}, 3'b000); end
  endtask

  // Two reads with req held high; second START follows the first DONE directly.
  task automatic test_back_to_back();
    logic [7:0] rd [2];
    logic [7:0] prev;
    rd[0] = 8'h96; rd[1] = 8'hC3;
    prev = 8'h00;
    tb_sb_en = 1'b1; tb_sb_v = 1'b1; tb_dbs_en = 1'b0;
    req = 1'b1; req_rd_wrt = 1'b0; req_slave_id = 2'b01; req_addr = 15'h0055; req_wdata = 8'h00;
    @(negedge clk);
    for (int t = 0; t < 2; t++) begin
      n_cmp++;
      if ({busy, data_bus_serial} !== 2'b10) begin
        n_bad++; $display("FAIL b2b_start%0d: got %b want %b", t, {busy, data_bus_serial}, 2'b10);
      end
      n_cmp++;
      if (rdata !== prev) begin n_bad++; $display("FAIL b2b_rdata_held%0d: got %h want %h", t, rdata, prev); end
      repeat (18) @(negedge clk);
      tb_sb_v = 1'b0;
      @(posedge clk); #1; tb_sb_en = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (slave_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_ack%0d: got %b want %b", t, slave_busy, 1'b1); end
      @(negedge clk);
      tb_sb_en = 1'b1; tb_sb_v = 1'b1;
      for (int b = 0; b < 8; b++) begin
        @(negedge clk);
        tb_dbs_en = 1'b1; tb_dbs_v = rd[t][7-b];
      end
      @(negedge clk);
      tb_dbs_en = 1'b0;
      n_cmp++;
      if ({done, error, rdata} !== {2'b10, rd[t]}) begin
        n_bad++; $display("FAIL b2b_done%0d: got %b/%h want 10/%h", t, {done, error}, rdata, rd[t]);
      end
      prev = rd[t];
      if (t == 0) begin
        req_slave_id = 2'b10; req_addr = 15'h0100;
      end else begin
        req = 1'b0;
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({busy, done, rdata} !== {2'b00, 8'hC3}) begin
      n_bad++; $display("FAIL b2b_after: got %b/%h want 00/c3", {busy, done}, rdata);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rstn = 1'b0; req = 1'b0; req_rd_wrt = 1'b0; req_slave_id = 2'b00; req_addr = '0; req_wdata = '0;
    tb_dbs_en = 1'b0; tb_dbs_v = 1'b0; tb_sb_en = 1'b0; tb_sb_v = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_reset_mid();
    test_req_ignored();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
